// File: rtl/clk_en_pkg.sv
// -----------------------------------------------------------------------------
// clk_en_pkg
// Shared definitions for the fractional clock-enable generator:
//   ACC_W_DEF      default width of MUL, DIV and the phase accumulator
//   CFG_ERR_REJECT level driven on cfg_err when a config write is refused
//   chan_cfg_t     one channel's {mul, div} ratio record (32-bit fields so it
//                  can carry any ACC_W up to 32 bits, zero-extended)
//   ratio_ok()     legality check for a requested ratio
// -----------------------------------------------------------------------------
package clk_en_pkg;

   localparam int ACC_W_DEF   = 16;
   localparam int CFG_FIELD_W = 32;

   localparam logic CFG_ERR_REJECT = 1'b1;

   typedef struct packed {
      logic [CFG_FIELD_W-1:0] mul;
      logic [CFG_FIELD_W-1:0] div;
   } chan_cfg_t;

   // A ratio is usable when the divisor is non-zero and MUL/DIV <= 1.
   function automatic logic ratio_ok(input chan_cfg_t cfg);
      return (cfg.div != '0) && (cfg.mul <= cfg.div);
   endfunction

endpackage

// File: rtl/clk_en_gen_if.sv
// -----------------------------------------------------------------------------
// clk_en_gen_if
// Runtime configuration bus of clk_en_gen.
//   cfg_we   one-cycle write strobe          (master -> slave)
//   cfg_ch   target channel index            (master -> slave)
//   cfg_mul  new MUL value                   (master -> slave)
//   cfg_div  new DIV value                   (master -> slave)
//   cfg_err  one-cycle "write rejected" pulse (slave -> master)
// -----------------------------------------------------------------------------
interface clk_en_gen_if
   import clk_en_pkg::*;
#(
   parameter int ACC_W = ACC_W_DEF
);
   logic             cfg_we;
   logic [2:0]       cfg_ch;
   logic [ACC_W-1:0] cfg_mul;
   logic [ACC_W-1:0] cfg_div;
   logic             cfg_err;

   modport master (output cfg_we, cfg_ch, cfg_mul, cfg_div, input  cfg_err);
   modport slave  (input  cfg_we, cfg_ch, cfg_mul, cfg_div, output cfg_err);
endinterface

// File: rtl/clk_en_chan.sv
// -----------------------------------------------------------------------------
// clk_en_chan
// One fractional enable channel. A phase accumulator advances by MUL each
// cycle and wraps modulo DIV; every wrap is a positive-phase strobe, every
// crossing of DIV/2 is a half-phase strobe. A settle counter tracks ce_p
// pulses since the last (re)configuration and drives locked / rst_out.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   sync_i          zero the accumulator, suppress this cycle's strobes
//   wr_i            accepted config write addressed to this channel
//   wr_mul_i/div_i  ratio carried by that write
//   ce_p_o, ce_n_o  registered positive / half-phase enables
//   locked_o        SETTLE ce_p pulses seen since configuration
//   rst_out_o       registered ~locked, forced high by a write
// -----------------------------------------------------------------------------
module clk_en_chan
   import clk_en_pkg::*;
#(
   parameter int ACC_W    = ACC_W_DEF,
   parameter int SETTLE   = 16,
   parameter int INIT_MUL = 1,
   parameter int INIT_DIV = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sync_i,
   input  logic             wr_i,
   input  logic [ACC_W-1:0] wr_mul_i,
   input  logic [ACC_W-1:0] wr_div_i,
   output logic             ce_p_o,
   output logic             ce_n_o,
   output logic             locked_o,
   output logic             rst_out_o
);

   localparam logic [7:0] SETTLE_C = 8'(SETTLE);

   logic [ACC_W-1:0] acc_q, acc_d;
   logic [ACC_W-1:0] mul_q, mul_d;
   logic [ACC_W-1:0] div_q, div_d;
   logic [7:0]       cnt_q, cnt_d;
   logic             ce_p_q, ce_p_d;
   logic             ce_n_q, ce_n_d;
   logic             locked_q, locked_d;
   logic             rst_out_q, rst_out_d;

   // One extra bit keeps acc + mul exact (both are <= DIV-1 / DIV).
   logic [ACC_W:0]   sum;
   logic [ACC_W:0]   acc_nx;
   logic [ACC_W-1:0] half;
   logic             wrap;
   logic             half_hit;

   always_comb begin
      sum    = {1'b0, acc_q} + {1'b0, mul_q};
      wrap   = (sum >= {1'b0, div_q});
      acc_nx = wrap ? (sum - {1'b0, div_q}) : sum;
      half   = div_q >> 1;

      // Half-phase crossing: either the accumulator climbs through DIV/2
      // without wrapping, or it wraps and lands at/above DIV/2.
      half_hit = ((acc_q < half) && (sum >= {1'b0, half}) && !wrap)
               || (wrap && (acc_nx >= {1'b0, half}));

      acc_d = (sync_i || wr_i) ? '0 : acc_nx[ACC_W-1:0];
      mul_d = wr_i ? wr_mul_i : mul_q;
      div_d = wr_i ? wr_div_i : div_q;

      ce_p_d = wrap && !sync_i;
      ce_n_d = half_hit && !sync_i;

      // Counts the ce_p pulses actually emitted; a write restarts settling.
      cnt_d = cnt_q;
      if (wr_i) begin
         cnt_d = '0;
      end else if (ce_p_d && (cnt_q != SETTLE_C)) begin
         cnt_d = cnt_q + 8'd1;
      end

      locked_d  = wr_i ? 1'b0 : (cnt_q == SETTLE_C);
      rst_out_d = wr_i ? 1'b1 : ~locked_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q     <= '0;
         mul_q     <= ACC_W'(INIT_MUL);
         div_q     <= ACC_W'(INIT_DIV);
         cnt_q     <= '0;
         ce_p_q    <= 1'b0;
         ce_n_q    <= 1'b0;
         locked_q  <= 1'b0;
         rst_out_q <= 1'b1;
      end else begin
         acc_q     <= acc_d;
         mul_q     <= mul_d;
         div_q     <= div_d;
         cnt_q     <= cnt_d;
         ce_p_q    <= ce_p_d;
         ce_n_q    <= ce_n_d;
         locked_q  <= locked_d;
         rst_out_q <= rst_out_d;
      end
   end

   assign ce_p_o    = ce_p_q;
   assign ce_n_o    = ce_n_q;
   assign locked_o  = locked_q;
   assign rst_out_o = rst_out_q;

endmodule

// File: rtl/clk_en_gen.sv
// -----------------------------------------------------------------------------
// clk_en_gen
// Fractional clock-enable generator: CHANNELS independent enable streams,
// each averaging CLK*MUL/DIV, all on the single fabric clock CLK.
// This level validates and decodes config writes, generates cfg_err and
// fans the phase-align sync out to every channel.
// Ports:
//   CLK, RST   clock, synchronous active-high reset
//   cfg        configuration bus (slave side), see clk_en_gen_if
//   sync       one-cycle pulse, zeroes every accumulator
//   ce_p/ce_n  per-channel positive / half-phase enables
//   locked     per-channel ratio-stable flag
//   rst_out    per-channel domain reset (registered ~locked)
// -----------------------------------------------------------------------------
module clk_en_gen
   import clk_en_pkg::*;
#(
   parameter int CHANNELS = 3,
   parameter int ACC_W    = ACC_W_DEF,
   parameter int SETTLE   = 16,
   parameter int INIT_MUL = 1,
   parameter int INIT_DIV = 2
) (
   input  logic                CLK,
   input  logic                RST,
   clk_en_gen_if.slave         cfg,
   input  logic                sync,
   output logic [CHANNELS-1:0] ce_p,
   output logic [CHANNELS-1:0] ce_n,
   output logic [CHANNELS-1:0] locked,
   output logic [CHANNELS-1:0] rst_out
);

   chan_cfg_t           wr_cfg;
   logic                ch_ok;
   logic                accept;
   logic [CHANNELS-1:0] wr_sel;
   logic                cfg_err_q, cfg_err_d;

   always_comb begin
      wr_cfg.mul = CFG_FIELD_W'(cfg.cfg_mul);
      wr_cfg.div = CFG_FIELD_W'(cfg.cfg_div);
      // Widened by one bit so CHANNELS = 8 still compares correctly.
      ch_ok      = ({1'b0, cfg.cfg_ch} < 4'(CHANNELS));
      accept     = cfg.cfg_we && ch_ok && ratio_ok(wr_cfg);
      cfg_err_d  = (cfg.cfg_we && !accept) ? CFG_ERR_REJECT : !CFG_ERR_REJECT;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         cfg_err_q <= !CFG_ERR_REJECT;
      end else begin
         cfg_err_q <= cfg_err_d;
      end
   end

   assign cfg.cfg_err = cfg_err_q;

   for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
      assign wr_sel[i] = accept && (cfg.cfg_ch == 3'(i));

      clk_en_chan #(
         .ACC_W    (ACC_W),
         .SETTLE   (SETTLE),
         .INIT_MUL (INIT_MUL),
         .INIT_DIV (INIT_DIV)
      ) u_chan (
         .clk       (CLK),
         .rst       (RST),
         .sync_i    (sync),
         .wr_i      (wr_sel[i]),
         .wr_mul_i  (cfg.cfg_mul),
         .wr_div_i  (cfg.cfg_div),
         .ce_p_o    (ce_p[i]),
         .ce_n_o    (ce_n[i]),
         .locked_o  (locked[i]),
         .rst_out_o (rst_out[i])
      );
   end

endmodule

// File: tb/tb_clk_en_gen.sv
// -----------------------------------------------------------------------------
// tb_clk_en_gen
// Directed bench for clk_en_gen (CHANNELS=3, ACC_W=16, SETTLE=16, 1/2 reset
// ratio). Inputs change 1 time unit after the rising edge; outputs are read
// at the same point, i.e. they show what the preceding edge registered.
// -----------------------------------------------------------------------------
module tb_clk_en_gen;

   logic       CLK = 1'b0;
   logic       RST;
   logic       sync;
   logic [2:0] ce_p, ce_n, locked, rst_out;

   int n_checks = 0;
   int n_err    = 0;

   clk_en_gen_if #(.ACC_W(16)) bus ();

   clk_en_gen #(
      .CHANNELS (3),
      .ACC_W    (16),
      .SETTLE   (16),
      .INIT_MUL (1),
      .INIT_DIV (2)
   ) dut (
      .CLK     (CLK),
      .RST     (RST),
      .cfg     (bus),
      .sync    (sync),
      .ce_p    (ce_p),
      .ce_n    (ce_n),
      .locked  (locked),
      .rst_out (rst_out)
   );

   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic write(input logic [2:0] ch, input logic [15:0] mul, input logic [15:0] div);
      bus.cfg_we  = 1'b1;
      bus.cfg_ch  = ch;
      bus.cfg_mul = mul;
      bus.cfg_div = div;
      tick();
      bus.cfg_we  = 1'b0;
   endtask

   task automatic bad_write(input string tag, input logic [2:0] ch,
                            input logic [15:0] mul, input logic [15:0] div);
      write(ch, mul, div);
      chk({tag, "_err_pulse"}, 32'(bus.cfg_err), 32'd1);
      tick();
      chk({tag, "_err_clear"}, 32'(bus.cfg_err), 32'd0);
   endtask

   // Expects RST to have just been released; walks the 1/2 ratio from the
   // first edge through lock (after the 16th ce_p) and rst_out release.
   task automatic lock_seq(input string pfx);
      tick();
      chk({pfx, "_e1_cen"}, 32'(ce_n), 32'd7);
      chk({pfx, "_e1_cep"}, 32'(ce_p), 32'd0);
      for (int k = 2; k <= 32; k++) begin
         tick();
         chk({pfx, "_cep"}, 32'(ce_p), (k % 2 == 0) ? 32'd7 : 32'd0);
         chk({pfx, "_cen"}, 32'(ce_n), (k % 2 == 0) ? 32'd0 : 32'd7);
         chk({pfx, "_unlocked"}, 32'(locked), 32'd0);
      end
      tick();
      chk({pfx, "_locked"}, 32'(locked), 32'd7);
      chk({pfx, "_rst_hold"}, 32'(rst_out), 32'd7);
      tick();
      chk({pfx, "_rst_rel"}, 32'(rst_out), 32'd0);
   endtask

   initial begin
      int np, nn, np2, lk_seen, rst_all;
      logic [2:0] exp_p [6];
      logic [2:0] exp_n [6];
      exp_p = '{3'd0, 3'd6, 3'd1, 3'd6, 3'd0, 3'd7};
      exp_n = '{3'd7, 3'd0, 3'd6, 3'd1, 3'd6, 3'd0};

      RST         = 1'b1;
      sync        = 1'b0;
      bus.cfg_we  = 1'b0;
      bus.cfg_ch  = '0;
      bus.cfg_mul = '0;
      bus.cfg_div = '0;
      repeat (3) tick();

      // Reset state
      chk("rst_cep",     32'(ce_p),        32'd0);
      chk("rst_cen",     32'(ce_n),        32'd0);
      chk("rst_locked",  32'(locked),      32'd0);
      chk("rst_rstout",  32'(rst_out),     32'd7);
      chk("rst_cfgerr",  32'(bus.cfg_err), 32'd0);

      // Default 1/2 ratio and lock sequence
      RST = 1'b0;
      lock_seq("boot");

      // ch0 = 25/48
      write(3'd0, 16'd25, 16'd48);
      chk("w0_locked", 32'(locked),      32'd6);
      chk("w0_rstout", 32'(rst_out),     32'd1);
      chk("w0_cfgerr", 32'(bus.cfg_err), 32'd0);
      np = 0; nn = 0;
      for (int k = 0; k < 48; k++) begin
         tick();
         np += int'(ce_p[0]);
         nn += int'(ce_n[0]);
      end
      chk("w0_cep_cnt",    32'(np), 32'd25);
      chk("w0_cen_range",  32'((nn == 24) || (nn == 25)), 32'd1);
      chk("w0_relocked",   32'(locked),  32'd7);
      chk("w0_rst_rel",    32'(rst_out), 32'd0);

      // ch1 = 7/7: ce_p every cycle, no ce_n
      write(3'd1, 16'd7, 16'd7);
      np = 0; nn = 0;
      for (int k = 0; k < 10; k++) begin
         tick();
         np += int'(ce_p[1]);
         nn += int'(ce_n[1]);
      end
      chk("full_cep_cnt", 32'(np), 32'd10);
      chk("full_cen_cnt", 32'(nn), 32'd0);

      // ch1 = 0/5: idle, never locks
      write(3'd1, 16'd0, 16'd5);
      np = 0; nn = 0; lk_seen = 0; rst_all = 1;
      for (int k = 0; k < 40; k++) begin
         tick();
         np += int'(ce_p[1]);
         nn += int'(ce_n[1]);
         if (locked[1])   lk_seen = 1;
         if (!rst_out[1]) rst_all = 0;
      end
      chk("idle_cep_cnt", 32'(np), 32'd0);
      chk("idle_cen_cnt", 32'(nn), 32'd0);
      chk("idle_locked",  32'(lk_seen), 32'd0);
      chk("idle_rstout",  32'(rst_all), 32'd1);

      // Rejected writes
      bad_write("bad_ratio", 3'd2, 16'd9, 16'd4);
      bad_write("bad_chan",  3'd5, 16'd1, 16'd2);
      bad_write("bad_div0",  3'd0, 16'd0, 16'd0);
      chk("bad_locked", 32'(locked),  32'd5);
      chk("bad_rstout", 32'(rst_out), 32'd2);
      np = 0; np2 = 0;
      for (int k = 0; k < 48; k++) begin
         tick();
         np  += int'(ce_p[0]);
         np2 += int'(ce_p[2]);
      end
      chk("bad_ch0_ratio", 32'(np),  32'd25);
      chk("bad_ch2_ratio", 32'(np2), 32'd24);

      // Phase align: ch0 = 1/3, ch1 = 1/2 (ch2 still 1/2)
      write(3'd0, 16'd1, 16'd3);
      write(3'd1, 16'd1, 16'd2);
      repeat (60) tick();
      chk("pre_sync_locked", 32'(locked), 32'd7);
      sync = 1'b1;
      tick();
      sync = 1'b0;
      chk("sync_cep", 32'(ce_p), 32'd0);
      chk("sync_cen", 32'(ce_n), 32'd0);
      for (int t = 0; t < 6; t++) begin
         tick();
         chk("post_sync_cep", 32'(ce_p), 32'(exp_p[t]));
         chk("post_sync_cen", 32'(ce_n), 32'(exp_n[t]));
      end
      chk("post_sync_locked", 32'(locked), 32'd7);

      // sync together with a write to ch2
      bus.cfg_we  = 1'b1;
      bus.cfg_ch  = 3'd2;
      bus.cfg_mul = 16'd1;
      bus.cfg_div = 16'd2;
      sync        = 1'b1;
      tick();
      bus.cfg_we  = 1'b0;
      sync        = 1'b0;
      chk("sw_locked", 32'(locked),  32'd3);
      chk("sw_rstout", 32'(rst_out), 32'd4);
      chk("sw_cep",    32'(ce_p),    32'd0);

      // Reset mid-stream discards runtime ratios
      RST = 1'b1;
      tick();
      chk("mid_rst_cep",    32'(ce_p),    32'd0);
      chk("mid_rst_cen",    32'(ce_n),    32'd0);
      chk("mid_rst_locked", 32'(locked),  32'd0);
      chk("mid_rst_rstout", 32'(rst_out), 32'd7);
      tick();
      RST = 1'b0;
      lock_seq("rerun");

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
